maint_cmd_arbiter: RTL
======================

// Module: maint_cmd_arbiter
// PURPOSE
//  Sits on the 128-bit command stream between ps_interface (M_AXIS_CMD) and sddt_core (S_AXIS_CMD).
//  Times DDR4 refresh, ZQ-calibration and periodic-read intervals, then injects maintenance command
//  words at host packet boundaries. It force-preempts a host packet when too many refreshes are postponed.
// PARAMETERS
//  CMD_WIDTH     128       command word width
//  REF_INTERVAL  5200      cycles between refresh ticks (tREFI 7.8us @ tCK 1.5ns); 0 = source off
//  ZQ_INTERVAL   85333333  cycles between ZQ ticks (128ms); 0 = source off
//  RD_INTERVAL   0         cycles between periodic-read ticks; 0 = source off
//  MAX_POSTPONE  8         ref_pending level that forces preemption (1..15)
//  REF_CMD/ZQ_CMD/RD_CMD  128'h1/128'h2/128'h3  injected words (encoding owned by cmd_scheduler)
// PORTS
//  c0_ddr4_clk   in   1    single clock
//  axi_resetn    in   1    synchronous, active-low reset
//  maint_en      in   1    1 = timers run / injection allowed; 0 = pure pass-through
//  s_cmd_tdata   in   128  host command word
//  s_cmd_tvalid  in   1    host valid
//  s_cmd_tlast   in   1    last word of host packet
//  s_cmd_tready  out  1    host ready
//  m_cmd_tdata   out  128  command word to sddt_core
//  m_cmd_tvalid  out  1    valid to sddt_core
//  m_cmd_tready  in   1    ready from sddt_core
//  ref_pending   out  4    outstanding refreshes
//  maint_err     out  1    sticky: ref_pending overflow
// BEHAVIOUR
//  Reset: state IDLE; m_cmd_tvalid=0, m_cmd_tdata=0, s_cmd_tready=0, ref_pending=0, zq/rd flags=0,
//   maint_err=0, timers loaded with INTERVAL-1. Reset mid-injection drops m_cmd_tvalid next edge.
//  Timers: 32-bit down-counters, running only when maint_en=1. At 0 they reload INTERVAL-1 and tick.
//   Ref tick: ref_pending+1, saturating at 15; a tick at 15 sets maint_err. ZQ/RD tick sets a 1-bit flag.
//   Ticks on a set flag coalesce. A simultaneous ref tick and ref injection handshake leaves the count unchanged.
//  maint_en=0: timers reload, pending/flags cleared; any in-flight injection completes its handshake first.
//  FSM IDLE (between host packets), HOST (inside packet), INJECT (driving maintenance word).
//   IDLE/HOST: pass-through, zero latency. m_cmd_tdata=s_cmd_tdata, m_cmd_tvalid=s_cmd_tvalid,
//    s_cmd_tready=m_cmd_tready.
//   IDLE: anything pending -> s_cmd_tready=0, m_cmd_tvalid=0 this cycle; INJECT next; ret=IDLE.
//    Host handshake with tlast=0 -> HOST. Pending check beats host valid in the same cycle.
//   HOST: handshake with tlast=1 -> IDLE. ref_pending>=MAX_POSTPONE -> s_cmd_tready=0 that cycle
//    (current beat not accepted); INJECT next; ret=HOST.
//   INJECT: word chosen at entry/after each handshake, priority REF>ZQ>RD. m_cmd_tvalid=1 (registered).
//    Word held stable until m_cmd_tready. Handshake clears/decrements its source.
//    ret=IDLE: continue while anything pending, else IDLE. ret=HOST: drain refs only, then HOST.
//    s_cmd_tready=0 throughout.
//  Host packets never reorder or lose words; injected words only appear between host words.
// CONFIGURATION
//  MAINT_STATS_EN defined: adds outputs ref_issued_cnt[31:0] and preempt_cnt[15:0].
//   ref_issued_cnt counts REF handshakes; preempt_cnt counts HOST->INJECT transitions. Both wrap, reset 0.
//   Both clear on axi_resetn only.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Pass-through: maint_en=0, 3-word packet, ready=1 -> 3 identical words out, no latency, no injection.
//  2 Refresh at idle: REF_INTERVAL=16, maint_en=1, no host -> REF_CMD about every 16 cycles; ref_pending 1->0.
//  3 Boundary wait: ref tick mid 10-word packet -> REF_CMD emitted after tlast word, not inside.
//  4 Forced preempt: MAX_POSTPONE=2, endless packet -> at ref_pending=2, 2 REF_CMD injected mid-packet.
//    The packet then resumes with no word lost.
//  5 Backpressure/overflow: m_cmd_tready=0 for 16*REF_INTERVAL -> ref_pending=15, maint_err=1.
//    REF_CMD stays stable while held.
//  6 Priority/coalesce: REF+ZQ+RD pending together -> order REF,ZQ,RD. Two ZQ ticks before injection -> one ZQ_CMD.

Source files
------------

// File: rtl/maint_cmd_arbiter.sv
// maint_cmd_arbiter: times DDR4 refresh / ZQ / periodic-read intervals and injects maintenance words into the host command stream
//   c0_ddr4_clk_i   in   1          single clock
//   axi_resetn_i    in   1          synchronous active-low reset
//   maint_en_i      in   1          1 = timers run and injection allowed, 0 = pure pass-through
//   s_cmd_*         in/out          host command stream (tdata/tvalid/tlast in, tready out)
//   m_cmd_*         out/in          command stream to sddt_core (tdata/tvalid out, tready in)
//   ref_pending_o   out  4          outstanding refreshes
//   maint_err_o     out  1          sticky ref_pending overflow
//   Optional: define MAINT_STATS_EN to add ref_issued_cnt_o[31:0] and preempt_cnt_o[15:0].
module maint_cmd_arbiter #(
    parameter int unsigned          CMD_WIDTH    = 128,
    parameter int unsigned          REF_INTERVAL = 5200,
    parameter int unsigned          ZQ_INTERVAL  = 85333333,
    parameter int unsigned          RD_INTERVAL  = 0,
    parameter int unsigned          MAX_POSTPONE = 8,
    parameter logic [CMD_WIDTH-1:0] REF_CMD      = CMD_WIDTH'(1),
    parameter logic [CMD_WIDTH-1:0] ZQ_CMD       = CMD_WIDTH'(2),
    parameter logic [CMD_WIDTH-1:0] RD_CMD       = CMD_WIDTH'(3)
) (
    input  logic                 c0_ddr4_clk_i,
    input  logic                 axi_resetn_i,
    input  logic                 maint_en_i,
    input  logic [CMD_WIDTH-1:0] s_cmd_tdata_i,
    input  logic                 s_cmd_tvalid_i,
    input  logic                 s_cmd_tlast_i,
    output logic                 s_cmd_tready_o,
    output logic [CMD_WIDTH-1:0] m_cmd_tdata_o,
    output logic                 m_cmd_tvalid_o,
    input  logic                 m_cmd_tready_i,
`ifdef MAINT_STATS_EN
    output logic [31:0]          ref_issued_cnt_o,
    output logic [15:0]          preempt_cnt_o,
`endif
    output logic [3:0]           ref_pending_o,
    output logic                 maint_err_o
);

    typedef enum logic [1:0] {IDLE, HOST, INJECT} state_t;
    typedef enum logic [1:0] {K_REF, K_ZQ, K_RD} kind_t;

    localparam logic [31:0] REF_RELOAD   = (REF_INTERVAL == 0) ? 32'd0 : 32'(REF_INTERVAL - 1);
    localparam logic [31:0] ZQ_RELOAD    = (ZQ_INTERVAL == 0) ? 32'd0 : 32'(ZQ_INTERVAL - 1);
    localparam logic [31:0] RD_RELOAD    = (RD_INTERVAL == 0) ? 32'd0 : 32'(RD_INTERVAL - 1);
    localparam logic [3:0]  POSTPONE_LVL = 4'(MAX_POSTPONE);

    state_t                 state_q, state_d;
    kind_t                  kind_q, kind_d, sel_kind;
    logic                   ret_host_q, ret_host_d;
    logic [CMD_WIDTH-1:0]   inj_data_q, inj_data_d, sel_data;
    logic [31:0]            ref_tmr_q, ref_tmr_d, zq_tmr_q, zq_tmr_d, rd_tmr_q, rd_tmr_d;
    logic [3:0]             ref_pending_q, ref_pending_d;
    logic                   zq_q, zq_d, rd_q, rd_d, err_q, err_d;
    logic                   ref_tick, zq_tick, rd_tick;
    logic                   ref_hs, zq_hs, rd_hs;
    logic                   any_pend, force_pre, more_any, more_ref;

    // Interval timers: hold at reload while disabled, tick on the cycle they reach zero.
    always_comb begin
        ref_tick  = maint_en_i && (REF_INTERVAL != 0) && (ref_tmr_q == '0);
        zq_tick   = maint_en_i && (ZQ_INTERVAL != 0) && (zq_tmr_q == '0);
        rd_tick   = maint_en_i && (RD_INTERVAL != 0) && (rd_tmr_q == '0);
        ref_tmr_d = (!maint_en_i || ref_tmr_q == '0) ? REF_RELOAD : ref_tmr_q - 32'd1;
        zq_tmr_d  = (!maint_en_i || zq_tmr_q == '0) ? ZQ_RELOAD : zq_tmr_q - 32'd1;
        rd_tmr_d  = (!maint_en_i || rd_tmr_q == '0) ? RD_RELOAD : rd_tmr_q - 32'd1;
    end

    // Request bookkeeping; an injected word is always valid, so ready alone completes it.
    always_comb begin
        ref_hs        = (state_q == INJECT) && m_cmd_tready_i && (kind_q == K_REF);
        zq_hs         = (state_q == INJECT) && m_cmd_tready_i && (kind_q == K_ZQ);
        rd_hs         = (state_q == INJECT) && m_cmd_tready_i && (kind_q == K_RD);
        ref_pending_d = ref_pending_q;
        err_d         = err_q;
        if (!maint_en_i)
            ref_pending_d = '0;
        else if (ref_tick && !ref_hs) begin
            if (ref_pending_q == 4'hF)
                err_d = 1'b1;
            else
                ref_pending_d = ref_pending_q + 4'd1;
        end else if (!ref_tick && ref_hs && ref_pending_q != '0)
            ref_pending_d = ref_pending_q - 4'd1;
        // A tick arriving with the handshake is a fresh request, so it wins over the clear.
        zq_d = maint_en_i && (zq_tick || (zq_q && !zq_hs));
        rd_d = maint_en_i && (rd_tick || (rd_q && !rd_hs));
    end

    always_comb begin
        any_pend       = maint_en_i && (ref_pending_q != '0 || zq_q || rd_q);
        force_pre      = maint_en_i && (ref_pending_q >= POSTPONE_LVL);
        more_any       = maint_en_i && (ref_pending_d != '0 || zq_d || rd_d);
        more_ref       = maint_en_i && (ref_pending_d != '0);
        // Selection looks at next-cycle request state so the word just completed is excluded.
        sel_kind       = (ref_pending_d != '0) ? K_REF : zq_d ? K_ZQ : K_RD;
        sel_data       = (ref_pending_d != '0) ? REF_CMD : zq_d ? ZQ_CMD : RD_CMD;
        state_d        = state_q;
        ret_host_d     = ret_host_q;
        kind_d         = kind_q;
        inj_data_d     = inj_data_q;
        m_cmd_tdata_o  = s_cmd_tdata_i;
        m_cmd_tvalid_o = s_cmd_tvalid_i;
        s_cmd_tready_o = m_cmd_tready_i;
        case (state_q)
            IDLE: begin
                if (any_pend) begin
                    m_cmd_tvalid_o = 1'b0;
                    s_cmd_tready_o = 1'b0;
                    state_d        = INJECT;
                    ret_host_d     = 1'b0;
                    kind_d         = sel_kind;
                    inj_data_d     = sel_data;
                end else if (s_cmd_tvalid_i && m_cmd_tready_i && !s_cmd_tlast_i)
                    state_d = HOST;
            end
            HOST: begin
                if (force_pre) begin
                    m_cmd_tvalid_o = 1'b0;
                    s_cmd_tready_o = 1'b0;
                    state_d        = INJECT;
                    ret_host_d     = 1'b1;
                    kind_d         = K_REF;
                    inj_data_d     = REF_CMD;
                end else if (s_cmd_tvalid_i && m_cmd_tready_i && s_cmd_tlast_i)
                    state_d = IDLE;
            end
            INJECT: begin
                m_cmd_tvalid_o = 1'b1;
                m_cmd_tdata_o  = inj_data_q;
                s_cmd_tready_o = 1'b0;
                if (m_cmd_tready_i) begin
                    // Mid-packet preemption only drains refreshes; ZQ/RD wait for a boundary.
                    if (ret_host_q ? more_ref : more_any) begin
                        kind_d     = sel_kind;
                        inj_data_d = sel_data;
                    end else
                        state_d = ret_host_q ? HOST : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!axi_resetn_i) begin
            m_cmd_tvalid_o = 1'b0;
            m_cmd_tdata_o  = '0;
            s_cmd_tready_o = 1'b0;
        end
    end

    always_ff @(posedge c0_ddr4_clk_i) begin
        if (!axi_resetn_i) begin
            state_q       <= IDLE;
            ret_host_q    <= 1'b0;
            kind_q        <= K_REF;
            inj_data_q    <= '0;
            ref_tmr_q     <= REF_RELOAD;
            zq_tmr_q      <= ZQ_RELOAD;
            rd_tmr_q      <= RD_RELOAD;
            ref_pending_q <= '0;
            zq_q          <= 1'b0;
            rd_q          <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            ret_host_q    <= ret_host_d;
            kind_q        <= kind_d;
            inj_data_q    <= inj_data_d;
            ref_tmr_q     <= ref_tmr_d;
            zq_tmr_q      <= zq_tmr_d;
            rd_tmr_q      <= rd_tmr_d;
            ref_pending_q <= ref_pending_d;
            zq_q          <= zq_d;
            rd_q          <= rd_d;
            err_q         <= err_d;
        end
    end

    assign ref_pending_o = ref_pending_q;
    assign maint_err_o   = err_q;

`ifdef MAINT_STATS_EN
    logic [31:0] ref_issued_q;
    logic [15:0] preempt_q;

    always_ff @(posedge c0_ddr4_clk_i) begin
        if (!axi_resetn_i) begin
            ref_issued_q <= '0;
            preempt_q    <= '0;
        end else begin
            if (ref_hs)
                ref_issued_q <= ref_issued_q + 32'd1;
            if (state_q == HOST && state_d == INJECT)
                preempt_q <= preempt_q + 16'd1;
        end
    end

    assign ref_issued_cnt_o = ref_issued_q;
    assign preempt_cnt_o    = preempt_q;
`endif

endmodule
